// File: rtl/dfr_core_axi_if.sv
// AXI4-Lite bundle for the DFR core register and memory window.
// master: address/data/valid/BREADY/RREADY; slave: ready/response/RDATA.
interface dfr_core_axi_if #(
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
   logic                  S_AXI_AWVALID;
   logic                  S_AXI_AWREADY;
   logic [31:0]           S_AXI_WDATA;
   logic [3:0]            S_AXI_WSTRB;
   logic                  S_AXI_WVALID;
   logic                  S_AXI_WREADY;
   logic [1:0]            S_AXI_BRESP;
   logic                  S_AXI_BVALID;
   logic                  S_AXI_BREADY;
   logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
   logic                  S_AXI_ARVALID;
   logic                  S_AXI_ARREADY;
   logic [31:0]           S_AXI_RDATA;
   logic [1:0]            S_AXI_RRESP;
   logic                  S_AXI_RVALID;
   logic                  S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWVALID,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARVALID,
      output S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWVALID,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARVALID,
      input  S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/dfr_core_axi.sv
// AXI4-Lite slave for the DFR core: CTRL register at 0x0000 plus a
// word-addressed window (0x0100+) into four memories chosen by CTRL[5:4].
// Ports: S_AXI_ACLK, S_AXI_ARESET (async, active-high), s_axi (slave).
module dfr_core_axi #(
   parameter int unsigned C_S_AXI_ACLK_FREQ_HZ = 100000000,
   parameter int C_S_AXI_DATA_WIDTH           = 32,
   parameter int C_S_AXI_ADDR_WIDTH           = 16,
   parameter int VIRTUAL_NODES                = 10,
   parameter int RESERVOIR_DATA_WIDTH         = 32,
   parameter int RESERVOIR_HISTORY_ADDR_WIDTH = 20,
   parameter int MEM_ADDR_WIDTH               = 8
) (
   input logic           S_AXI_ACLK,
   input logic           S_AXI_ARESET,
   dfr_core_axi_if.slave s_axi
);

   localparam int AW    = C_S_AXI_ADDR_WIDTH;
   localparam int MAW   = MEM_ADDR_WIDTH;
   localparam int RDW   = RESERVOIR_DATA_WIDTH;
   localparam int DEPTH = 1 << MAW;
   localparam logic [AW-1:0] WIN_BASE = AW'(256);
   localparam logic [31:0]   CTRL_RO  = 32'h0000_0002;

   if (C_S_AXI_DATA_WIDTH != 32 || RDW > 32 || RDW < 1 ||
       MAW >= AW || AW < 9 || VIRTUAL_NODES < 1 ||
       RESERVOIR_HISTORY_ADDR_WIDTH < 1 ||
       C_S_AXI_ACLK_FREQ_HZ == 0) begin : g_bad_cfg
      $error("dfr_core_axi: unsupported parameter set");
   end

   function automatic logic is_win(input logic [AW-1:0] a);
      return a >= WIN_BASE;
   endfunction

   function automatic logic [MAW-1:0] win_idx(input logic [AW-1:0] a);
      logic [AW-1:0] off;
      off = a - WIN_BASE;
      return off[MAW-1:0];
   endfunction

   logic          wr_rdy_q, wr_rdy_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]   wr_data_q, wr_data_d;
   logic          bvalid_q, bvalid_d;
   logic [31:0]   ctrl_q, ctrl_d;
   logic          rd_rdy_q, rd_rdy_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic          rvalid_q, rvalid_d;
   logic [31:0]   rdata_q, rdata_d;

   // Four memories, indexed by MEM_SEL; never reset.
   logic [RDW-1:0] mem_q [4][DEPTH];
   logic [RDW-1:0] mem_rd_q;

   logic wr_accept;
   logic rd_accept;
   logic unused_wstrb;

   assign unused_wstrb = ^s_axi.S_AXI_WSTRB;

   assign wr_accept = !wr_rdy_q
                    && s_axi.S_AXI_AWVALID
                    && s_axi.S_AXI_WVALID;
   // No new read address while a response is still pending.
   assign rd_accept = !rd_rdy_q && !rvalid_q
                    && s_axi.S_AXI_ARVALID;

   always_comb begin
      wr_rdy_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      bvalid_d  = bvalid_q;
      ctrl_d    = ctrl_q;
      rd_rdy_d  = 1'b0;
      rd_addr_d = rd_addr_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;

      if (wr_accept) begin
         wr_rdy_d  = 1'b1;
         wr_addr_d = s_axi.S_AXI_AWADDR;
         wr_data_d = s_axi.S_AXI_WDATA;
      end

      // A completing write keeps BVALID high: responses merge.
      if (wr_rdy_q) begin
         bvalid_d = 1'b1;
         if (wr_addr_q == '0) begin
            ctrl_d = wr_data_q & ~CTRL_RO;
         end
      end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end

      if (rd_accept) begin
         rd_rdy_d  = 1'b1;
         rd_addr_d = s_axi.S_AXI_ARADDR;
      end

      if (rd_rdy_q) begin
         rvalid_d = 1'b1;
         unique case (1'b1)
            (rd_addr_q == '0): rdata_d = ctrl_q;
            is_win(rd_addr_q): rdata_d = 32'(mem_rd_q);
            default:           rdata_d = '0;
         endcase
      end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         wr_rdy_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         bvalid_q  <= 1'b0;
         ctrl_q    <= '0;
         rd_rdy_q  <= 1'b0;
         rd_addr_q <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         wr_rdy_q  <= wr_rdy_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         bvalid_q  <= bvalid_d;
         ctrl_q    <= ctrl_d;
         rd_rdy_q  <= rd_rdy_d;
         rd_addr_q <= rd_addr_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   // Synchronous RAM: write one cycle after acceptance, read issued
   // on acceptance. A same-edge read of the written word sees old data.
   always_ff @(posedge S_AXI_ACLK) begin
      if (wr_rdy_q && !S_AXI_ARESET && is_win(wr_addr_q)) begin
         mem_q[ctrl_q[5:4]][win_idx(wr_addr_q)] <= wr_data_q[RDW-1:0];
      end
      if (rd_accept && !S_AXI_ARESET) begin
         mem_rd_q <= mem_q[ctrl_q[5:4]][win_idx(s_axi.S_AXI_ARADDR)];
      end
   end

   assign s_axi.S_AXI_AWREADY = wr_rdy_q;
   assign s_axi.S_AXI_WREADY  = wr_rdy_q;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = 2'b00;
   assign s_axi.S_AXI_ARREADY = rd_rdy_q;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign s_axi.S_AXI_RRESP   = 2'b00;

endmodule

// File: tb/tb_dfr_core_axi.sv
// Self-checking bench for dfr_core_axi: directed vector table,
// hand-written handshake/reset sequences and a randomized model run.
module tb_dfr_core_axi;

   logic clk;
   logic rst;

   dfr_core_axi_if #(.ADDR_WIDTH(16)) bus ();

   dfr_core_axi #(
      .C_S_AXI_ACLK_FREQ_HZ(100000000),
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(16),
      .VIRTUAL_NODES(10),
      .RESERVOIR_DATA_WIDTH(32),
      .RESERVOIR_HISTORY_ADDR_WIDTH(20),
      .MEM_ADDR_WIDTH(8)
   ) dut (
      .S_AXI_ACLK(clk),
      .S_AXI_ARESET(rst),
      .s_axi(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[$];

   // Reference model: register + four word arrays with written flags.
   logic [31:0] m_ctrl;
   logic [31:0] m_mem [4][256];
   bit          m_ok  [4][256];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      checks++;
      failures++;
      $display("FAIL %s: timeout waiting for handshake", name);
   endtask

   task automatic add_w(input logic [15:0] a, input logic [31:0] d);
      vec_t v;
      v.wr = 1'b1; v.addr = a; v.data = d; v.exp = '0;
      tbl.push_back(v);
   endtask

   task automatic add_r(input logic [15:0] a, input logic [31:0] e);
      vec_t v;
      v.wr = 1'b0; v.addr = a; v.data = '0; v.exp = e;
      tbl.push_back(v);
   endtask

   task automatic axi_write(input logic [15:0] a, input logic [31:0] d,
                            input bit br);
      int n;
      bus.S_AXI_AWADDR  = a;
      bus.S_AXI_WDATA   = d;
      bus.S_AXI_WSTRB   = 4'($urandom);
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WVALID  = 1'b1;
      bus.S_AXI_BREADY  = 1'b0;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!bus.S_AXI_AWREADY && n < 20);
      if (!bus.S_AXI_AWREADY) begin
         tmo("aw_handshake");
         bus.S_AXI_AWVALID = 1'b0;
         bus.S_AXI_WVALID  = 1'b0;
         return;
      end
      chk("wready_with_awready", 32'(bus.S_AXI_WREADY), 32'd1);
      @(posedge clk); #1;
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      chk("bvalid_set", 32'(bus.S_AXI_BVALID), 32'd1);
      chk("bresp", 32'(bus.S_AXI_BRESP), 32'd0);
      if (br) begin
         bus.S_AXI_BREADY = 1'b1;
         @(posedge clk); #1;
         bus.S_AXI_BREADY = 1'b0;
         chk("bvalid_clear", 32'(bus.S_AXI_BVALID), 32'd0);
      end
   endtask

   task automatic axi_read(input logic [15:0] a, output logic [31:0] d);
      int n;
      d = 'x;
      bus.S_AXI_ARADDR  = a;
      bus.S_AXI_ARVALID = 1'b1;
      bus.S_AXI_RREADY  = 1'b0;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!bus.S_AXI_ARREADY && n < 20);
      if (!bus.S_AXI_ARREADY) begin
         tmo("ar_handshake");
         bus.S_AXI_ARVALID = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus.S_AXI_ARVALID = 1'b0;
      if (!bus.S_AXI_RVALID) begin
         tmo("rvalid_latency");
         return;
      end
      d = bus.S_AXI_RDATA;
      chk("rresp", 32'(bus.S_AXI_RRESP), 32'd0);
      bus.S_AXI_RREADY = 1'b1;
      @(posedge clk); #1;
      bus.S_AXI_RREADY = 1'b0;
   endtask

   task automatic m_write(input logic [15:0] a, input logic [31:0] d);
      int sel;
      int idx;
      axi_write(a, d, 1'b1);
      if (a == 16'h0000) begin
         m_ctrl = d & ~32'h2;
      end else if (a >= 16'h0100) begin
         sel = int'(m_ctrl[5:4]);
         idx = (int'(a) - 256) % 256;
         m_mem[sel][idx] = d;
         m_ok[sel][idx]  = 1'b1;
      end
   endtask

   task automatic m_read(input logic [15:0] a);
      logic [31:0] got;
      int sel;
      int idx;
      axi_read(a, got);
      if (a == 16'h0000) begin
         chk("rand_ctrl_rd", got, m_ctrl);
      end else if (a < 16'h0100) begin
         chk("rand_resv_rd", got, 32'd0);
      end else begin
         sel = int'(m_ctrl[5:4]);
         idx = (int'(a) - 256) % 256;
         if (m_ok[sel][idx]) begin
            chk("rand_win_rd", got, m_mem[sel][idx]);
         end
      end
   endtask

   initial begin
      logic [31:0] got;
      int cnt;
      int n;
      logic [15:0] a;

      rst = 1'b1;
      bus.S_AXI_AWADDR  = '0;
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA   = '0;
      bus.S_AXI_WSTRB   = '0;
      bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_BREADY  = 1'b0;
      bus.S_AXI_ARADDR  = '0;
      bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY  = 1'b0;

      // Directed vectors.
      add_r(16'h0000, 32'h0000_0000);
      add_w(16'h0000, 32'hDEAD_BEEF);
      add_r(16'h0000, 32'hDEAD_BEED);
      for (int c = 0; c < 4; c++) begin
         add_w(16'h0000, 32'(c * 16));
         add_r(16'h0000, 32'(c * 16));
         for (int i = 0; i < 16; i++) begin
            add_w(16'(256 + i), 32'(i));
            add_r(16'(256 + i), 32'(i));
         end
      end
      add_w(16'h0000, 32'h0000_0000);
      add_w(16'h0103, 32'hAAAA_0003);
      add_w(16'h0000, 32'h0000_0020);
      add_w(16'h0103, 32'h5555_0003);
      add_r(16'h0103, 32'h5555_0003);
      add_w(16'h0000, 32'h0000_0000);
      add_r(16'h0103, 32'hAAAA_0003);
      add_w(16'h0000, 32'h0000_0030);
      add_r(16'h0103, 32'h0000_0003);
      add_w(16'h0000, 32'h0000_0032);
      add_r(16'h0000, 32'h0000_0030);
      add_w(16'h0000, 32'h0000_0000);
      add_r(16'h0040, 32'h0000_0000);
      add_w(16'h0040, 32'hFFFF_FFFF);
      add_r(16'h0040, 32'h0000_0000);
      add_r(16'h00FF, 32'h0000_0000);
      add_r(16'h0000, 32'h0000_0000);
      add_w(16'h0200, 32'h0000_0077);
      add_r(16'h0100, 32'h0000_0077);
      add_w(16'hFFFF, 32'hCAFE_0001);
      add_r(16'h01FF, 32'hCAFE_0001);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_handshake_outs",
          32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
               bus.S_AXI_ARREADY, bus.S_AXI_RVALID,
               bus.S_AXI_BRESP, bus.S_AXI_RRESP}), 32'd0);
      chk("reset_rdata", bus.S_AXI_RDATA, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[k]) begin
         if (tbl[k].wr) begin
            axi_write(tbl[k].addr, tbl[k].data, 1'b1);
         end else begin
            axi_read(tbl[k].addr, got);
            chk($sformatf("vec%0d_rd_%h", k, tbl[k].addr),
                got, tbl[k].exp);
         end
      end

      // ARVALID held through the RVALID handshake: one response only.
      axi_write(16'h0000, 32'h0, 1'b1);
      axi_write(16'h0110, 32'h1234_5678, 1'b1);
      bus.S_AXI_ARADDR  = 16'h0110;
      bus.S_AXI_ARVALID = 1'b1;
      bus.S_AXI_RREADY  = 1'b0;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!bus.S_AXI_RVALID && n < 20);
      if (!bus.S_AXI_RVALID) tmo("arhold_rvalid");
      chk("arhold_rdata", bus.S_AXI_RDATA, 32'h1234_5678);
      @(posedge clk); #1;
      chk("arhold_no_accept", 32'(bus.S_AXI_ARREADY), 32'd0);
      chk("arhold_rdata_stable", bus.S_AXI_RDATA, 32'h1234_5678);
      bus.S_AXI_RREADY = 1'b1;
      @(posedge clk); #1;
      bus.S_AXI_RREADY  = 1'b0;
      bus.S_AXI_ARVALID = 1'b0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (bus.S_AXI_RVALID || bus.S_AXI_ARREADY) cnt++;
      end
      chk("arhold_extra_resp", 32'(cnt), 32'd0);

      // BREADY low after a write, then a second write merges.
      axi_write(16'h0120, 32'h0000_0A0A, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("bvalid_held", 32'(bus.S_AXI_BVALID), 32'd1);
      axi_write(16'h0121, 32'h0000_0B0B, 1'b1);
      axi_read(16'h0120, got);
      chk("merged_wr0", got, 32'h0000_0A0A);
      axi_read(16'h0121, got);
      chk("merged_wr1", got, 32'h0000_0B0B);

      // Randomized traffic against the model.
      for (int s = 0; s < 4; s++) begin
         for (int i = 0; i < 256; i++) m_ok[s][i] = 1'b0;
      end
      m_write(16'h0000, 32'h0);
      for (int t = 0; t < 300; t++) begin
         n = int'($urandom_range(0, 99));
         a = 16'(256 + $urandom_range(0, 15)
                 + 256 * $urandom_range(0, 254));
         if (n < 12) m_write(16'h0000, $urandom);
         else if (n < 50) m_write(a, $urandom);
         else if (n < 90) m_read(a);
         else if (n < 95) m_read(16'($urandom_range(1, 255)));
         else m_read(16'h0000);
      end

      // Reset mid-write aborts it; memory contents survive.
      m_write(16'h0000, 32'h0);
      axi_write(16'h0105, 32'h0000_1234, 1'b1);
      bus.S_AXI_AWADDR  = 16'h0105;
      bus.S_AXI_WDATA   = 32'h0000_9999;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WVALID  = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!bus.S_AXI_AWREADY && n < 20);
      if (!bus.S_AXI_AWREADY) tmo("abort_aw");
      rst = 1'b1;
      #1;
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      chk("abort_outs",
          32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
               bus.S_AXI_BVALID}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      axi_write(16'h0000, 32'h0000_0030, 1'b1);
      axi_write(16'h0000, 32'h0000_0000, 1'b1);
      axi_read(16'h0105, got);
      chk("abort_mem_kept", got, 32'h0000_1234);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      axi_read(16'h0000, got);
      chk("ctrl_after_reset", got, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
